// File: rtl/mddr_pkg.sv
// Shared types and command encodings for the mobile-DDR init/refresh sequencer.
package mddr_pkg;

  typedef enum logic [3:0] {
    S_RESET,
    S_PWRUP,
    S_PRE,
    S_REF1,
    S_REF2,
    S_MRS,
    S_EMRS,
    S_IDLE,
    S_RPRE,
    S_RREF,
    S_WAIT
  } state_t;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0]  CMD_NOP  = 4'b0111;
  localparam logic [3:0]  CMD_PRE  = 4'b0010;
  localparam logic [3:0]  CMD_AREF = 4'b0001;
  localparam logic [3:0]  CMD_LMR  = 4'b0000;

  localparam logic [1:0]  BA_MR    = 2'b00;
  localparam logic [1:0]  BA_EMR   = 2'b10;

  localparam logic [13:0] A_PRE_ALL = 14'h0400;

endpackage

// File: rtl/mddr_wait_cnt.sv
// Loadable down-counter; o_done is high on the last cycle of the loaded wait.
module mddr_wait_cnt #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_value;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt == W'(1));

endmodule

// File: rtl/mddr_init_refresh.sv
// Mobile-DDR command sequencer: power-up init, then periodic auto-refresh
// arbitrated with the read/write controller via ref_req/ref_gnt.
module mddr_init_refresh
  import mddr_pkg::*;
#(
  parameter int          T_POWERUP_CYC = 10000,
  parameter int          T_RP          = 2,
  parameter int          T_RFC         = 6,
  parameter int          T_MRD         = 2,
  parameter int          T_REFI        = 390,
  parameter logic [13:0] MR_VALUE      = 14'h0031,
  parameter logic [13:0] EMR_VALUE     = 14'h0000,
  parameter int          MAX_PEND      = 8
) (
  input  logic        CLK_50M,
  input  logic        rst,
  input  logic        ref_gnt,
  output logic        cke,
  output logic        cs_n,
  output logic        ras_n,
  output logic        cas_n,
  output logic        we_n,
  output logic [13:0] a,
  output logic [1:0]  ba,
  output logic        bus_own,
  output logic        init_done,
  output logic        ref_req,
  output logic        ref_overflow
);

  localparam int CNT_W  = $clog2(T_POWERUP_CYC + T_RFC + 1);
  localparam int TMR_W  = $clog2(T_REFI + 1);
  localparam int PEND_W = $clog2(MAX_PEND + 1);

  state_t              r_state;
  state_t              r_ret;
  logic                r_cke;
  logic [3:0]          r_cmd;
  logic [13:0]         r_a;
  logic [1:0]          r_ba;
  logic                r_bus_own;
  logic                r_init_done;
  logic [TMR_W-1:0]    r_tmr;
  logic [PEND_W-1:0]   r_pend;
  logic                r_ovf;

  logic                w_load;
  logic [CNT_W-1:0]    w_load_val;
  logic                w_done;
  logic                w_tick;
  logic                w_aref;

  // The wait before S_IDLE is one cycle longer: idle entry is itself the next issue slot.
  always_comb begin
    w_load     = 1'b1;
    w_load_val = '0;
    case (r_state)
      S_RESET:        w_load_val = CNT_W'(T_POWERUP_CYC - 1);
      S_PRE, S_RPRE:  w_load_val = CNT_W'(T_RP - 1);
      S_REF1, S_REF2: w_load_val = CNT_W'(T_RFC - 1);
      S_RREF:         w_load_val = CNT_W'(T_RFC);
      S_MRS:          w_load_val = CNT_W'(T_MRD - 1);
      S_EMRS:         w_load_val = CNT_W'(T_MRD);
      default:        w_load     = 1'b0;
    endcase
  end

  mddr_wait_cnt #(.W(CNT_W)) u_wait (
    .i_clk   (CLK_50M),
    .i_rst   (rst),
    .i_load  (w_load),
    .i_value (w_load_val),
    .o_done  (w_done)
  );

  always_ff @(posedge CLK_50M or posedge rst) begin
    if (rst) begin
      r_state     <= S_RESET;
      r_ret       <= S_RESET;
      r_cke       <= 1'b0;
      r_cmd       <= CMD_NOP;
      r_a         <= '0;
      r_ba        <= '0;
      r_bus_own   <= 1'b1;
      r_init_done <= 1'b0;
    end else begin
      r_cke <= 1'b1;
      r_cmd <= CMD_NOP;
      r_a   <= '0;
      r_ba  <= '0;
      case (r_state)
        S_RESET: r_state <= S_PWRUP;
        S_PWRUP: if (w_done) r_state <= S_PRE;
        S_PRE: begin
          r_cmd <= CMD_PRE;  r_a <= A_PRE_ALL;
          r_ret <= S_REF1;   r_state <= S_WAIT;
        end
        S_REF1: begin
          r_cmd <= CMD_AREF; r_ret <= S_REF2; r_state <= S_WAIT;
        end
        S_REF2: begin
          r_cmd <= CMD_AREF; r_ret <= S_MRS;  r_state <= S_WAIT;
        end
        S_MRS: begin
          r_cmd <= CMD_LMR;  r_a <= MR_VALUE;  r_ba <= BA_MR;
          r_ret <= S_EMRS;   r_state <= S_WAIT;
        end
        S_EMRS: begin
          r_cmd <= CMD_LMR;  r_a <= EMR_VALUE; r_ba <= BA_EMR;
          r_ret <= S_IDLE;   r_state <= S_WAIT;
        end
        S_IDLE: begin
          if (ref_gnt && (r_pend != '0)) begin
            r_state   <= S_RPRE;
            r_bus_own <= 1'b1;
          end
        end
        S_RPRE: begin
          r_cmd <= CMD_PRE;  r_a <= A_PRE_ALL;
          r_ret <= S_RREF;   r_state <= S_WAIT;
        end
        S_RREF: begin
          r_cmd <= CMD_AREF; r_ret <= S_IDLE; r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (w_done) begin
            r_state <= r_ret;
            if (r_ret == S_IDLE) begin
              r_bus_own   <= 1'b0;
              r_init_done <= 1'b1;
            end
          end
        end
        default: r_state <= S_RESET;
      endcase
    end
  end

  assign w_aref = (r_state == S_RREF);
  assign w_tick = r_init_done && (r_tmr == TMR_W'(T_REFI - 1));

  // A tick and an AREF in the same cycle cancel out.
  always_ff @(posedge CLK_50M or posedge rst) begin
    if (rst) begin
      r_tmr  <= '0;
      r_pend <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_tick) begin
        r_tmr <= '0;
      end else if (r_init_done) begin
        r_tmr <= r_tmr + 1'b1;
      end
      if (w_tick && !w_aref) begin
        if (r_pend == PEND_W'(MAX_PEND)) r_ovf  <= 1'b1;
        else                             r_pend <= r_pend + 1'b1;
      end else if (w_aref && !w_tick) begin
        r_pend <= r_pend - 1'b1;
      end
    end
  end

  assign cke                        = r_cke;
  assign {cs_n, ras_n, cas_n, we_n} = r_cmd;
  assign a                          = r_a;
  assign ba                         = r_ba;
  assign bus_own                    = r_bus_own;
  assign init_done                  = r_init_done;
  assign ref_req                    = (r_state == S_IDLE) && (r_pend != '0);
  assign ref_overflow               = r_ovf;

endmodule

// File: doc/mddr_init_refresh.md
Name: mddr_init_refresh

Overview:
Command-bus sequencer for the board's 16-bit mobile DDR, sitting directly in front of the memory pins.
- After reset it runs the JEDEC LPDDR power-up sequence: CKE, 200 us NOP, PRECHARGE ALL, 2x AUTO REFRESH, MRS, EMRS.
- It then issues periodic auto-refresh, arbitrating with the read/write controller through a req/gnt handshake.
- Its command outputs feed the pad mux in front of RAM_CKE/RAM_CS_N/RAM_RAS_N/RAM_CAS_N/RAM_WS_N/RAM_A*/RAM_BA*.

Parameters:
T_POWERUP_CYC, 10000, NOP cycles with CKE high before first command (200 us at 50 MHz)
T_RP, 2, PRECHARGE to next command, cycles
T_RFC, 6, AUTO REFRESH to next command, cycles
T_MRD, 2, MRS/EMRS to next command, cycles
T_REFI, 390, refresh interval, cycles (7.8 us at 50 MHz)
MR_VALUE, 14'h0031, mode register: CL3, BL2, sequential
EMR_VALUE, 14'h0000, extended mode register: full array, full drive
MAX_PEND, 8, maximum postponed refreshes

Ports:
CLK_50M  in  1  system clock
rst  in  1  asynchronous active-high reset
ref_gnt  in  1  controller grants bus for refresh; sampled in S_IDLE only
cke  out  1  clock enable
cs_n  out  1  chip select
ras_n  out  1  row strobe
cas_n  out  1  column strobe
we_n  out  1  write enable
a  out  14  address
ba  out  2  bank address
bus_own  out  1  block owns the command bus; pad-mux select
init_done  out  1  init complete, sticky until reset
ref_req  out  1  refresh pending, requesting bus
ref_overflow  out  1  sticky: pending count saturated

Behaviour:
- Reset, asynchronous, while rst=1:
  - cke=0; NOP on {cs_n,ras_n,cas_n,we_n}=0111; a=0, ba=0.
  - bus_own=1; init_done=0, ref_req=0, ref_overflow=0.
  - State S_RESET, all counters 0.
- Command encodings {cs_n,ras_n,cas_n,we_n}:
  - NOP 0111; PRE 0010 with a[10]=1.
  - AREF 0001.
  - LMR 0000 with ba=00 for MRS, ba=10 for EMRS, a=value.
  - Every command is exactly one cycle; all other cycles are NOP with a=0, ba=0.
- Outputs are registered. A command appears on the pins the cycle after its state is entered.
- Wait counter spacing is exact: issue to next issue = T_RP / T_RFC / T_MRD cycles.
- Init FSM:
  - S_RESET -> S_PWRUP on the first clock after rst falls. cke goes to 1 on that edge and stays 1 thereafter.
  - S_PWRUP counts T_POWERUP_CYC NOP cycles.
  - Then: S_PRE -> wait T_RP -> S_REF1 -> wait T_RFC -> S_REF2 -> wait T_RFC -> S_MRS -> wait T_MRD -> S_EMRS -> wait T_MRD -> S_IDLE.
  - init_done=1 and bus_own=0 on S_IDLE entry.
- Refresh timer:
  - Starts at 0 on S_IDLE entry and counts continuously, including during refresh sequences.
  - On reaching T_REFI-1 it wraps to 0 and increments pending.
  - pending saturates at MAX_PEND; an increment attempt while saturated sets ref_overflow.
  - Timer increment and AREF decrement in the same cycle leave pending unchanged.
- ref_req = (state==S_IDLE) && pending!=0.
- Refresh sequence:
  - In S_IDLE with ref_gnt=1 and pending!=0: next state S_RPRE, bus_own=1 on that same edge.
  - Then PRE-all -> wait T_RP -> AREF (pending decremented on the AREF cycle) -> wait T_RFC -> S_IDLE, bus_own=0.
  - One refresh per grant. If pending is still nonzero, ref_req reasserts in S_IDLE and needs a new grant.
- ref_gnt when pending==0, or outside S_IDLE, is ignored.
- Reset mid-sequence, at any point: immediately return to reset values. A full init is re-run.

Decomposition:
- Package mddr_pkg holds:
  - state enum
  - 4-bit command encodings CMD_NOP/PRE/AREF/LMR
  - BA_MR/BA_EMR constants
- Sub-module mddr_wait_cnt: loadable down-counter, load value in, done pulse out. It is reused for the power-up wait and the tRP/tRFC/tMRD waits. The refresh timer is a separate free-running counter inside the top.

Test Plan:
(Parameters T_POWERUP_CYC=20, T_REFI=40.)
- Reset release -> cke=1 one cycle after rst falls, NOP for 20 cycles, PRE with a[10]=1, AREF at +2, AREF at +8, MRS a=0x0031 ba=0 at +14, EMRS a=0 ba=2 at +16, init_done=1 at +18.
- ref_gnt held 1 from reset release -> no effect before init_done; ref_req rises 40 cycles after S_IDLE entry; bus_own=1 next cycle; PRE then AREF 2 cycles later; bus_own=0 6 cycles after AREF.
- ref_gnt held 0 for 400 cycles after init -> pending saturates at 8, ref_overflow=1; then 8 successive grants -> exactly 8 AREFs, ref_req drops only after the last (modulo new expiries).
- Timer expiry on the same cycle as AREF with pending=1 -> pending stays 1, ref_req reasserts on return to S_IDLE.
- rst pulsed during S_REF2 and again during a refresh wait -> cke=0, bus_own=1, init_done=0 asynchronously; full init sequence repeats with identical timing.
